// File: rtl/spi_host_pkg.sv
// Shared definitions for the SPI host: flash/PSRAM opcodes, byte phases, helpers.
package spi_host_pkg;

    // Opcodes shared with the flash-emulating responder
    localparam logic [7:0] SPI_CMD_RDID = 8'h9F;
    localparam logic [7:0] SPI_CMD_RDSR = 8'h05;
    localparam logic [7:0] SPI_CMD_WREN = 8'h06;
    localparam logic [7:0] SPI_CMD_WRDS = 8'h04;
    localparam logic [7:0] SPI_CMD_READ = 8'h03;
    localparam logic [7:0] SPI_CMD_PP   = 8'h02;

    // Which part of the command the byte on the wire belongs to
    typedef enum logic [1:0] {
        PH_OP,
        PH_ADDR,
        PH_TX,
        PH_RX
    } phase_t;

    // Address bytes go out MSB first: index 0 is addr[23:16]
    function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [1:0] idx);
        case (idx)
            2'd0:    return addr[23:16];
            2'd1:    return addr[15:8];
            default: return addr[7:0];
        endcase
    endfunction

endpackage

// File: rtl/spi_host_shift.sv
// 8-bit SPI shifter: parallel load, shift-out on spi_clk fall, sample on spi_clk rise.
module spi_host_shift (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       shift,
    input  logic       sample,
    input  logic       sample_bit,
    output logic       mosi,
    output logic [7:0] rx_next,
    output logic       last,
    output logic       done
);

    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic [2:0] bit_cnt;

    assign mosi    = tx_sh[7];
    assign rx_next = {rx_sh[6:0], sample_bit};
    assign last    = (bit_cnt == 3'd7);

    // Shift registers and the per-byte sample counter
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!reset) begin
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
            done    <= 1'b0;
        end else if (load) begin
            tx_sh   <= load_data;
            bit_cnt <= '0;
            done    <= 1'b0;
        end else begin
            if (shift) begin
                tx_sh <= {tx_sh[6:0], 1'b0};
            end
            if (sample) begin
                rx_sh   <= rx_next;
                bit_cnt <= bit_cnt + 3'd1;
                if (last) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_host.sv
// Mode-0 single-bit SPI initiator: opcode, optional 24-bit address, tx bytes, rx bytes.
module spi_host #(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_op,
    input  logic        cmd_has_addr,
    input  logic [23:0] cmd_addr,
    input  logic [15:0] cmd_tx_len,
    input  logic [15:0] cmd_rx_len,
    input  logic [7:0]  tx_byte,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_byte,
    output logic        rx_strobe,
    output logic        busy,
    output logic        spi_clk,
    output logic        spi_cs,
    output logic        spi_do,
    input  logic        spi_di
);
    import spi_host_pkg::*;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [15:0]     GAP_LAST = 16'(CS_GAP - 1);

    state_t           state;
    phase_t           phase;
    logic [DIV_W-1:0] div_cnt;
    logic [15:0]      gap_cnt;
    logic [15:0]      byte_cnt;
    logic [1:0]       addr_idx;
    logic             stall;

    // Command fields captured at accept
    logic             lat_has_addr;
    logic [23:0]      lat_addr;
    logic [15:0]      lat_tx_len;
    logic [15:0]      lat_rx_len;

    // Events and next-byte selection
    logic             tick, accept, rise_evt, fall_evt, byte_end, resume;
    phase_t           nxt_phase;
    logic [1:0]       nxt_idx;
    logic [15:0]      nxt_cnt;
    logic             nxt_done;

    // Shifter interface
    logic             sh_load, sh_shift, sh_sample;
    logic [7:0]       sh_data;
    logic [7:0]       sh_rx_next;
    logic             sh_last, sh_done;

    spi_host_shift u_shift (
        .clk        (clk),
        .reset      (reset),
        .load       (sh_load),
        .load_data  (sh_data),
        .shift      (sh_shift),
        .sample     (sh_sample),
        .sample_bit (spi_di),
        .mosi       (spi_do),
        .rx_next    (sh_rx_next),
        .last       (sh_last),
        .done       (sh_done)
    );

    // Edge events, the byte that follows the current one, and shifter control
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        tick      = (div_cnt == DIV_LAST);
        accept    = (state == ST_IDLE) && cmd_valid;
        rise_evt  = tick && ((state == ST_SETUP) || ((state == ST_SHIFT) && !spi_clk && !stall));
        fall_evt  = tick && (state == ST_SHIFT) && spi_clk;
        byte_end  = fall_evt && sh_done;
        resume    = (state == ST_SHIFT) && stall && tx_valid;

        nxt_phase = phase;
        nxt_idx   = addr_idx;
        nxt_cnt   = byte_cnt;
        nxt_done  = 1'b0;
        if ((phase == PH_OP) && lat_has_addr) begin
            nxt_phase = PH_ADDR;
            nxt_idx   = 2'd0;
        end else if ((phase == PH_ADDR) && (addr_idx != 2'd2)) begin
            nxt_idx   = addr_idx + 2'd1;
        end else if ((phase == PH_TX || phase == PH_RX) && (byte_cnt > 16'd1)) begin
            nxt_cnt   = byte_cnt - 16'd1;
        end else if ((phase == PH_OP || phase == PH_ADDR) && (lat_tx_len != 16'd0)) begin
            nxt_phase = PH_TX;
            nxt_cnt   = lat_tx_len;
        end else if ((phase != PH_RX) && (lat_rx_len != 16'd0)) begin
            nxt_phase = PH_RX;
            nxt_cnt   = lat_rx_len;
        end else begin
            nxt_done  = 1'b1;
        end

        sh_load   = accept || byte_end || resume;
        sh_shift  = fall_evt && !sh_done;
        sh_sample = rise_evt;
        sh_data   = 8'h00;
        if (accept) begin
            sh_data = cmd_op;
        end else if (resume) begin
            sh_data = tx_byte;
        end else if (byte_end && !nxt_done) begin
            case (nxt_phase)
                PH_ADDR: sh_data = addr_byte(lat_addr, nxt_idx);
                PH_TX:   sh_data = tx_valid ? tx_byte : 8'h00;
                default: sh_data = 8'h00;
            endcase
        end
    end

    // Half-period divider; restarts on every edge and whenever the clock is parked
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if ((state == ST_IDLE) || stall || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Command FSM with registered bus and handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            phase        <= PH_OP;
            gap_cnt      <= '0;
            byte_cnt     <= '0;
            addr_idx     <= '0;
            stall        <= 1'b0;
            lat_has_addr <= 1'b0;
            lat_addr     <= '0;
            lat_tx_len   <= '0;
            lat_rx_len   <= '0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            tx_ready     <= 1'b0;
            rx_strobe    <= 1'b0;
            rx_byte      <= '0;
            spi_clk      <= 1'b0;
            spi_cs       <= 1'b1;
        end else begin
            tx_ready  <= 1'b0;
            rx_strobe <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_has_addr <= cmd_has_addr;
                        lat_addr     <= cmd_addr;
                        lat_tx_len   <= cmd_tx_len;
                        lat_rx_len   <= cmd_rx_len;
                        phase        <= PH_OP;
                        addr_idx     <= '0;
                        byte_cnt     <= '0;
                        spi_cs       <= 1'b0;
                        cmd_ready    <= 1'b0;
                        busy         <= 1'b1;
                        state        <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        spi_clk <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (stall) begin
                        if (tx_valid) begin
                            stall    <= 1'b0;
                            tx_ready <= 1'b1;
                        end
                    end else if (tick && !spi_clk) begin
                        spi_clk <= 1'b1;
                        if ((phase == PH_RX) && sh_last) begin
                            rx_strobe <= 1'b1;
                            rx_byte   <= sh_rx_next;
                        end
                    end else if (tick) begin
                        spi_clk <= 1'b0;
                        if (sh_done) begin
                            if (nxt_done) begin
                                state <= ST_HOLD;
                            end else begin
                                phase    <= nxt_phase;
                                addr_idx <= nxt_idx;
                                byte_cnt <= nxt_cnt;
                                if (nxt_phase == PH_TX) begin
                                    if (tx_valid) begin
                                        tx_ready <= 1'b1;
                                    end else begin
                                        stall <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        spi_cs  <= 1'b1;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt   <= '0;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 16'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_host.sv
// Bench for spi_host: behavioural flash responder, MOSI/MISO monitors, directed and random commands.
module tb_spi_host;
    import spi_host_pkg::*;

    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_op = '0;
    logic        cmd_has_addr = 1'b0;
    logic [23:0] cmd_addr = '0;
    logic [15:0] cmd_tx_len = '0;
    logic [15:0] cmd_rx_len = '0;
    logic [7:0]  tx_byte = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_byte;
    logic        rx_strobe;
    logic        busy;
    logic        spi_clk;
    logic        spi_cs;
    logic        spi_do;
    logic        spi_di = 1'b0;

    spi_host #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_has_addr(cmd_has_addr), .cmd_addr(cmd_addr),
        .cmd_tx_len(cmd_tx_len), .cmd_rx_len(cmd_rx_len),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_byte(rx_byte), .rx_strobe(rx_strobe), .busy(busy),
        .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_do(spi_do), .spi_di(spi_di)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Flash model state
    logic [7:0] id_bytes [3] = '{8'hC2, 8'h20, 8'h18};
    logic [7:0] status_reg = 8'h00;
    logic [7:0] txn_bytes [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    int         txn_rises = 0;
    int         bitn = 0;
    logic [7:0] cur = '0;

    // Observations
    logic [7:0] mosi_q [$];
    logic [7:0] rx_q [$];
    logic [7:0] exp_rx [$];
    logic [7:0] exp_mosi [$];
    logic [7:0] tx_data [8];
    int rises = 0, glitches = 0, tx_ready_cnt = 0, cs_rises = 0, cs_run = 0, last_gap = 0;

    function automatic logic [7:0] mem_at(input logic [23:0] a);
        return (a[7:0] * 8'd7) ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endfunction

    // Byte the flash returns at position b of the current transaction
    function automatic logic [7:0] resp(input int b);
        logic [23:0] a;
        a = {txn_bytes[1], txn_bytes[2], txn_bytes[3]};
        if (b == 0) return 8'h00;
        case (txn_bytes[0])
            SPI_CMD_RDID: return (b <= 3) ? id_bytes[b-1] : 8'h00;
            SPI_CMD_RDSR: return status_reg;
            SPI_CMD_READ: return (b >= 4) ? mem_at(a + 24'(b - 4)) : 8'h00;
            default:      return 8'h00;
        endcase
    endfunction

    // MOSI capture on rising spi_clk
    initial forever begin
        int k;
        @(posedge spi_clk);
        if (spi_cs) begin
            glitches++;
        end else begin
            cur = {cur[6:0], spi_do};
            bitn++;
            rises++;
            txn_rises++;
            if (bitn == 8) begin
                k = txn_rises / 8 - 1;
                if (k < 4) txn_bytes[k] = cur;
                mosi_q.push_back(cur);
                bitn = 0;
            end
        end
    end

    // MISO drive: next bit presented on falling spi_clk (or cs fall for the first bit)
    initial forever begin
        logic [7:0] v;
        @(negedge spi_clk or negedge spi_cs);
        if (!spi_cs) begin
            v = resp(txn_rises / 8);
            spi_di = v[7 - (txn_rises % 8)];
        end
    end

    // End of transaction clears the responder
    initial forever begin
        @(posedge spi_cs);
        cs_rises++;
        txn_rises = 0;
        bitn = 0;
        for (int i = 0; i < 4; i++) txn_bytes[i] = 8'h00;
    end

    // Strobe collection and cs-high run length, sampled on the falling clk edge
    initial forever begin
        @(negedge clk);
        if (rx_strobe) rx_q.push_back(rx_byte);
        if (tx_ready) tx_ready_cnt++;
        if (spi_cs) begin
            cs_run++;
        end else if (cs_run > 0) begin
            last_gap = cs_run;
            cs_run = 0;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        mosi_q.delete();
        rx_q.delete();
        rises = 0;
        glitches = 0;
        tx_ready_cnt = 0;
        cs_rises = 0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [7:0] op, input logic has_addr, input logic [23:0] addr,
                         input logic [15:0] txl, input logic [15:0] rxl);
        bit ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
        cmd_op = op; cmd_has_addr = has_addr; cmd_addr = addr;
        cmd_tx_len = txl; cmd_rx_len = rxl; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = ~op; cmd_has_addr = ~has_addr; cmd_addr = ~addr;
        cmd_tx_len = 16'hFFFF; cmd_rx_len = 16'hFFFF;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic has_addr, input logic [23:0] addr,
                           input int txl, input int rxl, input bit stall);
        int hdr;
        int highs;
        bit ok;
        logic [23:0] a;
        hdr = has_addr ? 4 : 1;
        a = addr;
        clear_obs();
        issue(op, has_addr, addr, 16'(txl), 16'(rxl));
        if (txl > 0) begin
            tx_byte = tx_data[0];
            tx_valid = 1'b1;
        end
        for (int i = 0; i < txl; i++) begin
            ok = 1'b0;
            for (int c = 0; c < 5000; c++) begin
                @(negedge clk);
                if (tx_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                check("tx_ready_timeout", 32'd0, 32'd1);
                break;
            end
            if (i + 1 < txl) begin
                if (stall && i == 0) begin
                    tx_valid = 1'b0;
                    for (int c = 0; c < 2000 && rises < 8 * (hdr + 1); c++) @(negedge clk);
                    repeat (4) @(negedge clk);
                    highs = 0;
                    for (int c = 0; c < 20; c++) begin
                        @(negedge clk);
                        if (spi_clk || spi_cs) highs++;
                    end
                    check("stall_clk_low_cs_low", 32'(highs), 32'd0);
                    check("stall_rises", 32'(rises), 32'(8 * (hdr + 1)));
                end
                tx_byte = tx_data[i+1];
                tx_valid = 1'b1;
            end
        end
        tx_valid = 1'b0;
        wait_idle();

        exp_mosi.delete();
        exp_mosi.push_back(op);
        if (has_addr) begin
            exp_mosi.push_back(a[23:16]);
            exp_mosi.push_back(a[15:8]);
            exp_mosi.push_back(a[7:0]);
        end
        for (int i = 0; i < txl; i++) exp_mosi.push_back(tx_data[i]);
        for (int i = 0; i < rxl; i++) exp_mosi.push_back(8'h00);

        check("mosi_count", 32'(mosi_q.size()), 32'(exp_mosi.size()));
        for (int i = 0; i < exp_mosi.size(); i++)
            check("mosi_byte", (i < mosi_q.size()) ? {24'd0, mosi_q[i]} : 32'hxxxxxxxx, {24'd0, exp_mosi[i]});
        check("rising_edges", 32'(rises), 32'(8 * exp_mosi.size()));
        check("clk_with_cs_high", 32'(glitches), 32'd0);
        check("cs_single_window", 32'(cs_rises), 32'd1);
        check("tx_ready_count", 32'(tx_ready_cnt), 32'(txl));
        check("rx_count", 32'(rx_q.size()), 32'(exp_rx.size()));
        for (int i = 0; i < exp_rx.size(); i++)
            check("rx_byte", (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hxxxxxxxx, {24'd0, exp_rx[i]});
        check("cs_high_after", {31'd0, spi_cs}, 32'd1);
        check("ready_after", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        logic [23:0] ra;
        int rl, tl;
        bit ok;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_spi_cs", {31'd0, spi_cs}, 32'd1);
        check("rst_spi_clk", {31'd0, spi_clk}, 32'd0);
        check("rst_spi_do", {31'd0, spi_do}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        check("rst_rx_strobe", {31'd0, rx_strobe}, 32'd0);
        check("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // RDID
        exp_rx = '{8'hC2, 8'h20, 8'h18};
        run_cmd(SPI_CMD_RDID, 1'b0, 24'h0, 0, 3, 1'b0);

        // READ at 0x123456, two bytes
        exp_rx = '{mem_at(24'h123456), mem_at(24'h123457)};
        run_cmd(SPI_CMD_READ, 1'b1, 24'h123456, 0, 2, 1'b0);

        // WREN: opcode only
        exp_rx.delete();
        run_cmd(SPI_CMD_WREN, 1'b0, 24'h0, 0, 0, 1'b0);

        // PP with the second data byte held back
        tx_data[0] = 8'hA5;
        tx_data[1] = 8'h5A;
        run_cmd(SPI_CMD_PP, 1'b1, 24'h000100, 2, 0, 1'b1);

        // Randomised READ / PP / RDSR
        for (int r = 0; r < 3; r++) begin
            ra = 24'($urandom);
            rl = $urandom_range(1, 4);
            exp_rx.delete();
            for (int i = 0; i < rl; i++) exp_rx.push_back(mem_at(ra + 24'(i)));
            run_cmd(SPI_CMD_READ, 1'b1, ra, 0, rl, 1'b0);

            tl = $urandom_range(1, 3);
            for (int i = 0; i < tl; i++) tx_data[i] = 8'($urandom);
            exp_rx.delete();
            run_cmd(SPI_CMD_PP, 1'b1, 24'($urandom), tl, 0, 1'b0);

            status_reg = 8'($urandom);
            exp_rx = '{status_reg};
            run_cmd(SPI_CMD_RDSR, 1'b0, 24'h0, 0, 1, 1'b0);
        end

        // Reset during the second address byte
        clear_obs();
        issue(SPI_CMD_READ, 1'b1, 24'h123456, 16'd0, 16'd4);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (rises >= 20) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("abort_progress_timeout", 32'd0, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_cs_immediate", {31'd0, spi_cs}, 32'd1);
        check("abort_clk_low", {31'd0, spi_clk}, 32'd0);
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rx_q.delete();
        tx_ready_cnt = 0;
        repeat (40) @(negedge clk);
        check("abort_no_rx_strobe", 32'(rx_q.size()), 32'd0);
        check("abort_cs_stays_high", {31'd0, spi_cs}, 32'd1);
        check("abort_ready_after", {31'd0, cmd_ready}, 32'd1);
        status_reg = 8'($urandom);
        exp_rx = '{status_reg};
        run_cmd(SPI_CMD_RDSR, 1'b0, 24'h0, 0, 1, 1'b0);

        // Back-to-back RDSR with cmd_valid held
        status_reg = 8'($urandom);
        clear_obs();
        cmd_op = SPI_CMD_RDSR; cmd_has_addr = 1'b0; cmd_addr = '0;
        cmd_tx_len = 16'd0; cmd_rx_len = 16'd1;
        @(negedge clk);
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (!cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("b2b_first_accept_timeout", 32'd0, 32'd1);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("b2b_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle();
        check("b2b_rx_count", 32'(rx_q.size()), 32'd2);
        check("b2b_rx0", (rx_q.size() > 0) ? {24'd0, rx_q[0]} : 32'hxxxxxxxx, {24'd0, status_reg});
        check("b2b_rx1", (rx_q.size() > 1) ? {24'd0, rx_q[1]} : 32'hxxxxxxxx, {24'd0, status_reg});
        check("b2b_rises", 32'(rises), 32'd32);
        check("b2b_cs_windows", 32'(cs_rises), 32'd2);
        check("b2b_gap_min4", {31'd0, (last_gap >= 4)}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
